// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - instruction memory load/fetch controller in front of a single-port SRAM
//
// Purpose:
//   Owns a single-port synchronous SRAM. It either writes a program into the SRAM
//   (LOAD) or streams sequential instruction words out of it (FETCH). Fetched words
//   go through a small output FIFO, which the downstream side pops.
//
// Ports:
//   clk0, rst0                  clock (shared with the SRAM); synchronous active-high reset
//   start, halt                 begin fetching at pc 0 / stop fetching and return to IDLE
//   ld_valid, ld_addr, ld_data  program-load write request; ld_ready acknowledges a beat
//   redir_valid, redir_pc       pc redirect while fetching
//   out_valid, out_ready        fetched-word handshake
//   out_pc, out_data            address and data of the FIFO head
//   csb0, web0, addr0, din0     SRAM control (active-low select/write), address, write data
//   dout0                       SRAM read data, valid the cycle after a read is issued

module imem_fetch_ctrl #(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 4,
  localparam int DEPTH = 2
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  start,
  input  logic                  halt,
  input  logic                  ld_valid,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_ready,
  input  logic                  redir_valid,
  input  logic [ADDR_WIDTH-1:0] redir_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FETCH = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;

  // One outstanding read at most; its pc travels alongside so the word is tagged
  // with the address that produced it.
  logic                  inflight_q;
  logic [ADDR_WIDTH-1:0] inflight_pc_q;

  // Output FIFO storage and bookkeeping.
  logic [DATA_WIDTH-1:0] buf_data_q [DEPTH];
  logic [ADDR_WIDTH-1:0] buf_pc_q   [DEPTH];
  logic                  rd_ptr_q;
  logic                  wr_ptr_q;
  logic [1:0]            occ_q;

  logic fetching;
  logic flush;
  logic credit_ok;
  logic rd_issue;
  logic wr_issue;
  logic push;
  logic pop;

  always_comb begin
    fetching  = (state_q == ST_FETCH);
    // halt and redirect both discard everything buffered or in flight.
    flush     = fetching && (halt || redir_valid);
    // Occupancy plus the outstanding read must leave room, so a response
    // always has a free FIFO slot when it lands.
    credit_ok = (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd2);
    rd_issue  = fetching && credit_ok && !halt && !redir_valid && !rst0;
    wr_issue  = (state_q == ST_LOAD) && ld_valid && !rst0;
    // A response is dropped if it arrives in the same cycle as a flush.
    push      = inflight_q && !flush;
    out_valid = (occ_q != 2'd0) && !rst0;
    pop       = out_valid && out_ready;
  end

  // Next-state and pc logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      ST_IDLE: begin
        if (ld_valid) begin
          state_d = ST_LOAD;
        end else if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
        end
      end
      ST_LOAD: begin
        if (!ld_valid) begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (halt) begin
          state_d = ST_IDLE;
        end else if (redir_valid) begin
          pc_d = redir_pc;
        end else if (rd_issue) begin
          pc_d = pc_q + ADDR_WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // SRAM port drive; addr0 parks on pc when idle and is forced to 0 in reset.
  always_comb begin
    csb0     = 1'b1;
    web0     = 1'b1;
    addr0    = pc_q;
    din0     = '0;
    ld_ready = wr_issue;
    if (rst0) begin
      addr0 = '0;
    end else if (wr_issue) begin
      csb0  = 1'b0;
      web0  = 1'b0;
      addr0 = ld_addr;
      din0  = ld_data;
    end else if (rd_issue) begin
      csb0 = 1'b0;
    end
  end

  always_ff @(posedge clk0) begin
    if (rst0) begin
      state_q       <= ST_IDLE;
      pc_q          <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      occ_q         <= 2'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= rd_issue;
      if (rd_issue) begin
        inflight_pc_q <= pc_q;
      end
      if (flush) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
        occ_q    <= 2'd0;
      end else begin
        if (push) begin
          wr_ptr_q <= ~wr_ptr_q;
        end
        if (pop) begin
          rd_ptr_q <= ~rd_ptr_q;
        end
        case ({push, pop})
          2'b10:   occ_q <= occ_q + 2'd1;
          2'b01:   occ_q <= occ_q - 2'd1;
          default: occ_q <= occ_q;
        endcase
      end
    end
  end

  // Payload storage needs no reset; occupancy decides what is visible.
  always_ff @(posedge clk0) begin
    if (!rst0 && push) begin
      buf_data_q[wr_ptr_q] <= dout0;
      buf_pc_q[wr_ptr_q]   <= inflight_pc_q;
    end
  end

  always_comb begin
    out_pc   = buf_pc_q[rd_ptr_q];
    out_data = buf_data_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - self-checking bench for imem_fetch_ctrl
module tb_imem_fetch_ctrl;

  logic       clk0 = 1'b0;
  logic       rst0, start, halt, ld_valid, ld_ready, redir_valid;
  logic [3:0] ld_addr, redir_pc, out_pc, addr0;
  logic [1:0] ld_data, out_data, din0, dout0;
  logic       out_valid, out_ready, csb0, web0;
  logic       preload;

  logic [1:0] mem [16];
  logic [1:0] ref_mem [16];
  int checks = 0;
  int errors = 0;

  imem_fetch_ctrl #(.DATA_WIDTH(2), .ADDR_WIDTH(4)) dut (
    .clk0(clk0), .rst0(rst0), .start(start), .halt(halt),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .redir_valid(redir_valid), .redir_pc(redir_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_data(out_data),
    .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0), .dout0(dout0)
  );

  always #5 clk0 = ~clk0;

  // Single-port synchronous SRAM model.
  always @(posedge clk0) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= 2'((i * 3 + 1) & 3);
    end else if (!csb0) begin
      if (!web0) mem[addr0] <= din0;
      else       dout0 <= mem[addr0];
    end
  end

  typedef struct {
    logic rst, start, halt, ldv; logic [3:0] lda; logic [1:0] ldd;
    logic rv; logic [3:0] rpc; logic ordy;
    logic csb, web; logic [3:0] addr; logic [1:0] din; logic ldr, ov;
    logic [3:0] opc; logic [1:0] odat; logic chk_addr;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; halt = 0; ld_valid = 0; ld_addr = 0; ld_data = 0;
    redir_valid = 0; redir_pc = 0; out_ready = 0;
  endtask

  task automatic collect(input int n, input logic [3:0] first_pc, input string tag);
    int got = 0;
    int budget = 0;
    logic [3:0] epc = first_pc;
    out_ready = 1;
    while (got < n && budget < 200) begin
      @(negedge clk0);
      if (out_valid) begin
        chk($sformatf("%s_pc%0d", tag, got), out_pc, epc);
        chk($sformatf("%s_data%0d", tag, got), out_data, ref_mem[epc]);
        epc = epc + 4'd1;
        got++;
      end
      tick();
      budget++;
    end
    if (got < n) chk($sformatf("%s_timeout", tag), got, n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int reads, late, unstable, found, seen4;
    clear_inputs();
    rst0 = 1; preload = 1;
    for (int i = 0; i < 16; i++) ref_mem[i] = 2'((i * 3 + 1) & 3);
    ref_mem[0] = 3; ref_mem[1] = 2; ref_mem[2] = 1; ref_mem[3] = 0;

    //             rst st hl ldv lda ldd rv rpc rdy  csb web addr din ldr ov opc odat chka
    tbl[0]  = '{1, 0, 0, 1, 5, 2, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0, 1};
    tbl[1]  = '{0, 0, 0, 1, 0, 3, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0, 1};
    tbl[2]  = '{0, 0, 0, 1, 0, 3, 0, 0, 0,   0, 0, 0, 3, 1, 0, 0, 0, 1};
    tbl[3]  = '{0, 0, 0, 1, 1, 2, 0, 0, 0,   0, 0, 1, 2, 1, 0, 0, 0, 1};
    tbl[4]  = '{0, 0, 0, 1, 2, 1, 0, 0, 0,   0, 0, 2, 1, 1, 0, 0, 0, 1};
    tbl[5]  = '{0, 0, 0, 1, 3, 0, 0, 0, 0,   0, 0, 3, 0, 1, 0, 0, 0, 1};
    tbl[6]  = '{0, 0, 1, 0, 0, 0, 1, 7, 0,   1, 1, 0, 0, 0, 0, 0, 0, 1};
    tbl[7]  = '{0, 0, 1, 0, 0, 0, 1, 9, 0,   1, 1, 0, 0, 0, 0, 0, 0, 1};
    tbl[8]  = '{0, 1, 0, 0, 0, 0, 0, 0, 1,   1, 1, 0, 0, 0, 0, 0, 0, 1};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 0, 0, 0, 0, 0, 0, 1};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 1, 0, 0, 0, 0, 0, 1};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1,   1, 1, 2, 0, 0, 1, 0, 3, 1};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 2, 0, 0, 1, 1, 2, 1};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 3, 0, 0, 0, 0, 0, 1};
    tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 1,   1, 1, 4, 0, 0, 1, 2, 1, 1};
    tbl[15] = '{0, 0, 0, 1, 9, 3, 0, 0, 1,   0, 1, 4, 0, 0, 1, 3, 0, 1};
    tbl[16] = '{0, 0, 1, 0, 0, 0, 1, 9, 1,   1, 1, 5, 0, 0, 0, 0, 0, 1};
    tbl[17] = '{0, 0, 0, 0, 0, 0, 0, 0, 1,   1, 1, 0, 0, 0, 0, 0, 0, 0};

    tick();
    preload = 0;
    tick();

    for (int r = 0; r < 18; r++) begin
      rst0 = tbl[r].rst; start = tbl[r].start; halt = tbl[r].halt;
      ld_valid = tbl[r].ldv; ld_addr = tbl[r].lda; ld_data = tbl[r].ldd;
      redir_valid = tbl[r].rv; redir_pc = tbl[r].rpc; out_ready = tbl[r].ordy;
      @(negedge clk0);
      chk($sformatf("v%0d_csb0", r), csb0, tbl[r].csb);
      chk($sformatf("v%0d_web0", r), web0, tbl[r].web);
      if (tbl[r].chk_addr) chk($sformatf("v%0d_addr0", r), addr0, tbl[r].addr);
      chk($sformatf("v%0d_din0", r), din0, tbl[r].din);
      chk($sformatf("v%0d_ld_ready", r), ld_ready, tbl[r].ldr);
      chk($sformatf("v%0d_out_valid", r), out_valid, tbl[r].ov);
      if (tbl[r].ov) begin
        chk($sformatf("v%0d_out_pc", r), out_pc, tbl[r].opc);
        chk($sformatf("v%0d_out_data", r), out_data, tbl[r].odat);
      end
      tick();
    end

    // Backpressure: two reads fill both credits, then the port goes quiet.
    clear_inputs();
    start = 1;
    tick();
    start = 0;
    reads = 0; late = 0; unstable = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk0);
      if (!csb0 && web0) reads++;
      if (c >= 2 && !csb0) late++;
      if (out_valid && (out_pc != 4'd0 || out_data != ref_mem[0])) unstable++;
      tick();
    end
    @(negedge clk0);
    chk("bp_reads", reads, 2);
    chk("bp_csb_quiet", late, 0);
    chk("bp_head_stable", unstable, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_out_pc", out_pc, 0);
    tick();
    // Release and run past pc 15 to see the wrap to 0.
    collect(18, 4'd0, "wrap");
    halt = 1;
    @(negedge clk0);
    chk("halt_no_read", csb0, 1);
    tick();
    halt = 0;

    // Redirect while the pc-4 read is outstanding.
    start = 1;
    tick();
    start = 0;
    out_ready = 1;
    found = 0; seen4 = 0;
    for (int c = 0; c < 50 && found == 0; c++) begin
      @(negedge clk0);
      if (out_valid && out_pc == 4'd4) seen4 = 1;
      if (!csb0 && web0 && addr0 == 4'd4) found = 1;
      tick();
    end
    chk("redir_found_rd4", found, 1);
    redir_valid = 1; redir_pc = 4'd9;
    @(negedge clk0);
    chk("redir_no_read", csb0, 1);
    tick();
    redir_valid = 0;
    @(negedge clk0);
    chk("redir_flush", out_valid, 0);
    chk("redir_resume_csb", csb0, 0);
    chk("redir_resume_addr", addr0, 9);
    chk("redir_no_pc4", seen4, 0);
    tick();
    collect(3, 4'd9, "redir");
    halt = 1;
    tick();
    halt = 0;

    // Reset with the buffer full.
    out_ready = 0;
    start = 1;
    tick();
    start = 0;
    for (int c = 0; c < 6; c++) tick();
    @(negedge clk0);
    chk("rst_pre_full", out_valid, 1);
    tick();
    rst0 = 1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk0);
      chk($sformatf("rst_out_valid%0d", c), out_valid, 0);
      chk($sformatf("rst_csb0_%0d", c), csb0, 1);
      chk($sformatf("rst_addr0_%0d", c), addr0, 0);
      tick();
    end
    rst0 = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk0);
      chk($sformatf("post_rst_valid%0d", c), out_valid, 0);
      chk($sformatf("post_rst_csb%0d", c), csb0, 1);
      tick();
    end
    start = 1;
    tick();
    start = 0;
    collect(2, 4'd0, "restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 2, SRAM word width; ADDR_WIDTH, default 4, SRAM address width; DEPTH, fixed 2, output buffer entries.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset: clk0 (rising edge) and rst0.
REQ-003 The ports SHALL be (name  direction  width  meaning):
- clk0  in  1  clock, shared with the SRAM
- rst0  in  1  synchronous active-high reset
- start  in  1  begin fetching at pc 0
- halt  in  1  stop fetching and return to IDLE
- ld_valid  in  1  program-load write request
- ld_addr  in  ADDR_WIDTH  load address
- ld_data  in  DATA_WIDTH  load data
- ld_ready  out  1  load write accepted this cycle
- redir_valid  in  1  pc redirect
- redir_pc  in  ADDR_WIDTH  redirect target
- out_valid  out  1  fetched word available
- out_ready  in  1  downstream accepts
- out_pc  out  ADDR_WIDTH  address of the fetched word
- out_data  out  DATA_WIDTH  fetched word
- csb0  out  1  SRAM chip select, active low
- web0  out  1  SRAM write enable, active low
- addr0  out  ADDR_WIDTH  SRAM address
- din0  out  DATA_WIDTH  SRAM write data
- dout0  in  DATA_WIDTH  SRAM read data

Function
REQ-004 The FSM SHALL have three states: IDLE, LOAD and FETCH.
REQ-005 In IDLE, ld_valid SHALL move the FSM to LOAD; otherwise start SHALL move it to FETCH with pc=0.
REQ-006 In LOAD, ld_ready SHALL equal ld_valid, and each accepted beat SHALL drive csb0=0, web0=0, addr0=ld_addr, din0=ld_data in the same cycle.
REQ-007 LOAD SHALL return to IDLE in the first cycle where ld_valid=0; that cycle SHALL NOT issue a write.
REQ-008 ld_ready SHALL be 0 in FETCH; ld_valid in FETCH SHALL be ignored.
REQ-009 csb0, web0, addr0 and din0 SHALL be combinational from registered state and current inputs; when no access is issued, csb0=1, web0=1, addr0=pc, din0=0.
REQ-010 A read SHALL issue in FETCH when occupancy + inflight < 2 and neither halt nor redir_valid is asserted.
- A read drives csb0=0, web0=1, addr0=pc.
- After a read, pc SHALL increment modulo 2^ADDR_WIDTH (15 wraps to 0).
REQ-011 Read timing SHALL be:
- read issued in cycle N;
- dout0 captured into the buffer at the clk0 edge ending cycle N+1, tagged with the issuing pc;
- out_valid=1 no earlier than cycle N+2.
REQ-012 At most one read SHALL be in flight; inflight is a 1-bit register.
REQ-013 The buffer SHALL be a 2-entry FIFO.
- Head drives out_pc and out_data.
- out_valid = (occupancy != 0).
- Pop on out_valid && out_ready.
- Simultaneous push and pop SHALL leave occupancy unchanged and preserve order.
REQ-014 The buffer SHALL never overflow; the credit rule in REQ-010 guarantees this.
REQ-015 redir_valid in FETCH SHALL, in one cycle:
- flush the buffer (out_valid=0 next cycle);
- kill any in-flight response so it is never pushed;
- set pc=redir_pc;
- issue no read.
Reads SHALL resume the following cycle from redir_pc.
REQ-016 halt in FETCH SHALL flush the buffer, kill any in-flight response, and go to IDLE; halt SHALL take priority over redir_valid.
REQ-017 redir_valid and halt SHALL be ignored outside FETCH; start SHALL be ignored outside IDLE.
REQ-018 out_data and out_pc SHALL hold stable while out_valid=1 and out_ready=0.

Reset
REQ-019 While rst0=1, the outputs SHALL be csb0=1, web0=1, ld_ready=0, addr0=0 and din0=0.
REQ-020 At the first edge with rst0=1, the block SHALL set state=IDLE, pc=0, occupancy=0 and inflight=0, so out_valid=0 next cycle.
REQ-021 A reset asserted mid-read SHALL discard the in-flight response.
REQ-022 A reset asserted mid-load SHALL issue no further write.

Verification
REQ-023 Load: ld_valid beats writing addresses 0..3 with data 3,2,1,0 -> ld_ready=1 on each beat; csb0=0 and web0=0 on exactly 4 cycles; FSM back in IDLE.
REQ-024 Fetch: start with out_ready=1 -> first out_valid two cycles after the first read; out_pc sequence 0,1,2,3 with out_data 3,2,1,0.
REQ-025 Backpressure: out_ready=0 for 10 cycles -> occupancy saturates at 2; csb0 stays 1 once 2 credits are used; no entry is lost or duplicated after release.
REQ-026 Wrap: fetch past pc=15 -> the next out_pc is 0.
REQ-027 Redirect: redir_pc=9 while a read of pc 4 is in flight -> the pc-4 word never appears; the next out_pc is 9.
REQ-028 Reset mid-fetch with buffer full -> out_valid=0 and csb0=1 during reset; after reset the FSM is in IDLE until start.
